// File: rtl/midi_pkg.sv
// Shared constants, receiver state type and message-length helper for the
// MIDI input front end.
package midi_pkg;

  localparam logic [7:0] STATUS_MIN = 8'h80;
  localparam logic [7:0] SYS_MIN    = 8'hF0;
  localparam logic [3:0] PC_NIBBLE  = 4'hC;
  localparam logic [3:0] CP_NIBBLE  = 4'hD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Program change and channel pressure carry one data byte; the rest carry two.
  function automatic logic needs_two_data(input logic [7:0] status_byte);
    return !((status_byte[7:4] == PC_NIBBLE) || (status_byte[7:4] == CP_NIBBLE));
  endfunction

endpackage

// File: rtl/midi_input_frontend_if.sv
// Output bundle of the MIDI input front end: the completed message, learn
// state and button press pulses.
interface midi_input_frontend_if;
  logic [7:0] status;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [1:0] bytes_cnt;
  logic       cmd_completed;
  logic       save_mode;
  logic [1:0] btn_index;

  modport master (
    output status, data1, data2, bytes_cnt, cmd_completed, save_mode, btn_index
  );

  modport slave (
    input status, data1, data2, bytes_cnt, cmd_completed, save_mode, btn_index
  );
endinterface

// File: rtl/btn_debounce.sv
// Synchronises one active-low push button and debounces it into a
// pressed level that changes only after a long enough stable period.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst_i,
  input  logic i_btn_n,
  output logic o_pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_state;
  logic [CW-1:0] r_cnt;
  logic          w_pressed_raw;

  assign w_pressed_raw = ~r_sync2;
  assign o_pressed     = r_state;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      if (w_pressed_raw == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_state <= ~r_state;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/midi_input_frontend.sv
// MIDI input front end: three debounced buttons, an 8N1 UART receiver,
// channel-message assembly and the learn (save) mode flag.
module midi_input_frontend
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 3200,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst_i,
  input  logic board_btn,
  input  logic btn2_pin_1,
  input  logic btn2_pin_2,
  input  logic midi_rx,
  midi_input_frontend_if.master o_midi
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  // ---------------- buttons ----------------
  logic [2:0] w_btn_n;
  logic [2:0] w_pressed;
  logic [2:0] r_pressed_prev;
  logic [2:0] w_rise;
  logic [1:0] w_idx;
  logic [1:0] r_btn_index;

  assign w_btn_n = {btn2_pin_2, btn2_pin_1, board_btn};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk      (clk),
        .rst_i    (rst_i),
        .i_btn_n  (w_btn_n[gi]),
        .o_pressed(w_pressed[gi])
      );
    end
  endgenerate

  assign w_rise = w_pressed & ~r_pressed_prev;

  always_comb begin
    w_idx = 2'd0;
    if (w_rise[0])      w_idx = 2'd1;
    else if (w_rise[1]) w_idx = 2'd2;
    else if (w_rise[2]) w_idx = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_pressed_prev <= '0;
      r_btn_index    <= 2'd0;
    end else begin
      r_pressed_prev <= w_pressed;
      r_btn_index    <= w_idx;
    end
  end

  // ---------------- UART receiver ----------------
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic          w_rx, w_fall;
  rx_state_t     r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          w_half, w_full;
  logic          w_cnt_clr, w_bit_tick, w_byte_valid, w_frame_err;

  assign w_rx   = r_rx_s2;
  assign w_fall = r_rx_prev & ~r_rx_s2;
  assign w_half = (r_cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign w_full = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_bit_tick   = 1'b0;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_fall) w_state_next = START;
      end
      START: if (w_half) begin
        // Line back high at mid start bit: treat as a glitch.
        w_cnt_clr    = 1'b1;
        w_state_next = w_rx ? IDLE : DATA;
      end
      DATA: if (w_full) begin
        w_cnt_clr  = 1'b1;
        w_bit_tick = 1'b1;
        if (r_bit_idx == 3'd7) w_state_next = STOP;
      end
      STOP: if (w_full) begin
        w_cnt_clr    = 1'b1;
        w_state_next = IDLE;
        w_byte_valid = w_rx;
        w_frame_err  = ~w_rx;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_rx_s1   <= midi_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (r_state == IDLE) r_bit_idx <= 3'd0;
      if (w_bit_tick) begin
        r_shift   <= {w_rx, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

  // ---------------- message assembly ----------------
  logic       r_pending, r_need_two, r_got_first;
  logic [7:0] r_sh_status, r_sh_data1;
  logic [7:0] r_status, r_data1, r_data2;
  logic [1:0] r_bytes_cnt;
  logic       r_cmd_completed, r_save_mode;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_pending       <= 1'b0;
      r_need_two      <= 1'b0;
      r_got_first     <= 1'b0;
      r_sh_status     <= 8'd0;
      r_sh_data1      <= 8'd0;
      r_status        <= 8'd0;
      r_data1         <= 8'd0;
      r_data2         <= 8'd0;
      r_bytes_cnt     <= 2'd0;
      r_cmd_completed <= 1'b0;
      r_save_mode     <= 1'b0;
    end else begin
      if ((r_btn_index != 2'd0) && r_save_mode) r_save_mode <= 1'b0;
      if (!r_cmd_completed)                       r_save_mode <= 1'b0;

      if (w_frame_err) begin
        r_pending   <= 1'b0;
        r_got_first <= 1'b0;
      end else if (w_byte_valid) begin
        if ((r_shift >= STATUS_MIN) && (r_shift < SYS_MIN)) begin
          r_pending       <= 1'b1;
          r_got_first     <= 1'b0;
          r_sh_status     <= r_shift;
          r_sh_data1      <= 8'd0;
          r_need_two      <= needs_two_data(r_shift);
          r_cmd_completed <= 1'b0;
          r_save_mode     <= 1'b0;
        end else if (!r_shift[7] && r_pending) begin
          if (!r_got_first && r_need_two) begin
            r_sh_data1  <= r_shift;
            r_got_first <= 1'b1;
          end else begin
            // Last data byte: publish the whole message in one edge.
            r_pending       <= 1'b0;
            r_got_first     <= 1'b0;
            r_status        <= r_sh_status;
            r_data1         <= r_need_two ? r_sh_data1 : r_shift;
            r_data2         <= r_need_two ? r_shift : 8'd0;
            r_bytes_cnt     <= r_need_two ? 2'd3 : 2'd2;
            r_cmd_completed <= 1'b1;
            r_save_mode     <= 1'b1;
          end
        end
      end
    end
  end

  assign o_midi.status        = r_status;
  assign o_midi.data1         = r_data1;
  assign o_midi.data2         = r_data2;
  assign o_midi.bytes_cnt     = r_bytes_cnt;
  assign o_midi.cmd_completed = r_cmd_completed;
  assign o_midi.save_mode     = r_save_mode;
  assign o_midi.btn_index     = r_btn_index;
endmodule

// File: tb/tb_midi_input_frontend.sv
// Scoreboard bench for midi_input_frontend: stimulus pushes expected
// messages and button events, a negedge monitor pops and compares them.
module tb_midi_input_frontend;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic board_btn = 1'b1;
  logic btn2_pin_1 = 1'b1;
  logic btn2_pin_2 = 1'b1;
  logic midi_rx = 1'b1;

  midi_input_frontend_if o_midi_if ();

  midi_input_frontend #(.CLKS_PER_BIT(16), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .board_btn (board_btn),
    .btn2_pin_1(btn2_pin_1),
    .btn2_pin_2(btn2_pin_2),
    .midi_rx   (midi_rx),
    .o_midi    (o_midi_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] bc;
  } msg_t;

  typedef struct {
    logic [1:0] idx;
    logic       sm;
  } btn_t;

  msg_t exp_msg[$];
  btn_t exp_btn[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int act);
    n_total++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    midi_rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      cyc(16);
    end
    midi_rx = stop_bit;
    cyc(16);
    midi_rx = 1'b1;
    cyc(4);
    $display("byte %02h stop=%0d sent", b, stop_bit);
  endtask

  task automatic expect_msg(input logic [7:0] st, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [1:0] bc);
    msg_t m;
    m.st = st; m.d1 = d1; m.d2 = d2; m.bc = bc;
    exp_msg.push_back(m);
  endtask

  task automatic expect_btn(input logic [1:0] idx, input logic sm);
    btn_t e;
    e.idx = idx; e.sm = sm;
    exp_btn.push_back(e);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_msg.size() != 0 || exp_btn.size() != 0) && t < 400) begin
      cyc(1);
      t++;
    end
    if (exp_msg.size() != 0) begin
      chk("msg_timeout", exp_msg.size(), 0);
      exp_msg.delete();
    end
    if (exp_btn.size() != 0) begin
      chk("btn_timeout", exp_btn.size(), 0);
      exp_btn.delete();
    end
  endtask

  task automatic press(input int which, input int hold);
    if (which == 1) board_btn = 1'b0;
    else if (which == 2) btn2_pin_1 = 1'b0;
    else btn2_pin_2 = 1'b0;
    cyc(hold);
    board_btn = 1'b1; btn2_pin_1 = 1'b1; btn2_pin_2 = 1'b1;
    cyc(20);
    $display("button %0d pressed for %0d cycles", which, hold);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] st, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [1:0] bc, input logic cc);
    chk({tag, "_status"}, o_midi_if.status, st);
    chk({tag, "_data1"},  o_midi_if.data1, d1);
    chk({tag, "_data2"},  o_midi_if.data2, d2);
    chk({tag, "_bytes"},  o_midi_if.bytes_cnt, bc);
    chk({tag, "_cmdc"},   o_midi_if.cmd_completed, cc);
  endtask

  // Monitor
  logic prev_cc = 1'b0;
  logic sm_chk  = 1'b0;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_cc = 1'b0;
      sm_chk  = 1'b0;
    end else begin
      if (sm_chk) begin
        chk("save_mode_after_bind", o_midi_if.save_mode, 0);
        sm_chk = 1'b0;
      end
      if (o_midi_if.cmd_completed && !prev_cc) begin
        if (exp_msg.size() == 0) begin
          fail_now("unexpected_msg", o_midi_if.status);
        end else begin
          msg_t m;
          m = exp_msg.pop_front();
          chk("msg_status", o_midi_if.status, m.st);
          chk("msg_data1", o_midi_if.data1, m.d1);
          chk("msg_data2", o_midi_if.data2, m.d2);
          chk("msg_bytes", o_midi_if.bytes_cnt, m.bc);
          chk("msg_save_mode", o_midi_if.save_mode, 1);
          $display("msg %02h %02h %02h n=%0d", o_midi_if.status, o_midi_if.data1,
                   o_midi_if.data2, o_midi_if.bytes_cnt);
        end
      end
      prev_cc = o_midi_if.cmd_completed;
      if (o_midi_if.btn_index != 2'd0) begin
        if (exp_btn.size() == 0) begin
          fail_now("unexpected_btn", o_midi_if.btn_index);
        end else begin
          btn_t e;
          e = exp_btn.pop_front();
          chk("btn_index", o_midi_if.btn_index, e.idx);
          chk("btn_save_mode", o_midi_if.save_mode, e.sm);
          if (e.sm) sm_chk = 1'b1;
          $display("btn_index=%0d save_mode=%0d", o_midi_if.btn_index, o_midi_if.save_mode);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(5);
    check_outputs("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
    chk("reset_save_mode", o_midi_if.save_mode, 0);
    chk("reset_btn_index", o_midi_if.btn_index, 0);
    rst_i = 1'b0;
    cyc(10);

    // Three-byte control change
    expect_msg(8'hB0, 8'h2E, 8'h7F, 2'd3);
    send_byte(8'hB0, 1'b1); send_byte(8'h2E, 1'b1); send_byte(8'h7F, 1'b1);
    wait_drain();

    // Two-byte program change, then a stray data byte
    expect_msg(8'hC0, 8'h42, 8'h00, 2'd2);
    send_byte(8'hC0, 1'b1); send_byte(8'h42, 1'b1);
    wait_drain();
    send_byte(8'h55, 1'b1);
    cyc(10);
    check_outputs("stray", 8'hC0, 8'h42, 8'h00, 2'd2, 1'b1);
    chk("stray_save_mode", o_midi_if.save_mode, 1);

    // Bouncing button 2 shorter than the debounce window
    btn2_pin_1 = 1'b0; cyc(1); btn2_pin_1 = 1'b1; cyc(1);
    btn2_pin_1 = 1'b0; cyc(2); btn2_pin_1 = 1'b1; cyc(1);
    cyc(20);
    // Real press binds the pending message
    expect_btn(2'd2, 1'b1);
    press(2, 20);
    wait_drain();
    chk("btn2_unbound", o_midi_if.save_mode, 0);

    // Pitch bend then learn and play presses on button 1
    expect_msg(8'hE0, 8'h00, 8'h40, 2'd3);
    send_byte(8'hE0, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h40, 1'b1);
    wait_drain();
    expect_btn(2'd1, 1'b1);
    press(1, 20);
    expect_btn(2'd1, 1'b0);
    press(1, 20);
    wait_drain();

    // Short low glitch, then a clean message
    midi_rx = 1'b0; cyc(4); midi_rx = 1'b1; cyc(20);
    expect_msg(8'hC0, 8'h44, 8'h00, 2'd2);
    send_byte(8'hC0, 1'b1); send_byte(8'h44, 1'b1);
    wait_drain();

    // Framing error mid-message, then a good note-on
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h40, 1'b0);
    cyc(10);
    chk("framing_no_completion", o_midi_if.cmd_completed, 0);
    expect_msg(8'h90, 8'h3C, 8'h40, 2'd3);
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h40, 1'b1);
    wait_drain();

    // Reset in the middle of a byte
    midi_rx = 1'b0;
    cyc(16 + 16 * 3);
    rst_i = 1'b1;
    cyc(1);
    check_outputs("midreset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
    chk("midreset_save_mode", o_midi_if.save_mode, 0);
    rst_i = 1'b0;
    midi_rx = 1'b1;
    cyc(40);
    expect_msg(8'hC0, 8'h43, 8'h00, 2'd2);
    send_byte(8'hC0, 1'b1); send_byte(8'h43, 1'b1);
    wait_drain();

    cyc(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/midi_input_frontend.md
Name: midi_input_frontend

Overview:
- Front end of the MIDI controller. It debounces three active-low push buttons into one-cycle button-index pulses.
- It receives a 31250-baud MIDI stream and assembles complete channel messages.
- It tracks a "learn" (save) mode: a freshly received message can be bound to the next pressed button.
- Feeds the memory map and MIDI-out logic of the controller top level.

Parameters:
- CLKS_PER_BIT, 3200: clk cycles per MIDI bit (100 MHz / 31250).
- DEBOUNCE_CYCLES, 2000000: consecutive stable cycles required before a debounced button changes state.

Ports:
- clk  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- board_btn  in  1  button 1, active-low, asynchronous
- btn2_pin_1  in  1  button 2, active-low, asynchronous
- btn2_pin_2  in  1  button 3, active-low, asynchronous
- midi_rx  in  1  MIDI serial input; idle high, asynchronous
- status  out  8  status byte of the last completed message
- data1  out  8  first data byte (0 if unused)
- data2  out  8  second data byte (0 if unused)
- bytes_cnt  out  2  total bytes in the message, status included (2 or 3)
- cmd_completed  out  1  level: a complete message is held on the outputs
- save_mode  out  1  level: completed message not yet bound to a button
- btn_index  out  2  one-cycle pulse, 1..3 = button pressed; 0 = none

Behaviour:
- Reset (rst_i=1 at a clk edge):
  - Outputs cleared: status, data1, data2, bytes_cnt, cmd_completed, save_mode, btn_index all 0.
  - Internal state cleared: receiver returns to IDLE, debounced states go to released, assembly is cleared.
- Synchronisation: every asynchronous input passes through a 2-FF synchroniser before use.
- Debounce, per button:
  - Counter resets whenever the synced input equals the debounced state.
  - When the input has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced state toggles and the counter clears.
- Press pulse:
  - The cycle after a debounced released->pressed transition, btn_index = that button's number for exactly 1 cycle.
  - Release produces nothing.
  - If several buttons transition in the same cycle, the lowest index wins; the others are dropped.
- UART receiver, 8N1, LSB first. States IDLE -> START -> DATA -> STOP:
  - IDLE: a synced falling edge moves to START.
  - START: waits CLKS_PER_BIT/2 cycles; if the line is high, it is a glitch and returns to IDLE.
  - DATA: samples 8 bits, each CLKS_PER_BIT cycles apart (mid-bit).
  - STOP: samples once more; 1 means the byte is valid; 0 is a framing error, which discards the byte and clears message assembly.
  - In every case the receiver then returns to IDLE.
- Message assembly on a valid byte:
  - 0x80-0xEF: status byte. Clears the shadow data and sets cmd_completed=0. Expects 1 data byte for high nibble C or D, otherwise 2.
  - 0xF0-0xFF: ignored; assembly state is untouched.
  - Data byte (MSB 0) while a status is pending: stored into the shadow registers.
  - Data byte with no pending status, or after the message is already complete: ignored. There is no running status.
- Completion:
  - On the cycle after the last needed data byte's stop-bit sample, these update atomically: status, data1, data2 (0 if unused), bytes_cnt (2 or 3). cmd_completed goes to 1.
  - The outputs hold until the next status byte or reset.
- Save mode, registered:
  - Set to 1 on the completion cycle.
  - Cleared the cycle after a btn_index pulse seen while save_mode=1. That pulse is the binding event: the consumer sees btn_index!=0 with save_mode=1 for exactly one cycle.
  - Also cleared whenever cmd_completed=0.
  - A button press with save_mode=0 is a normal "play" press.
- Simultaneous events:
  - A press in the completion cycle sees the old save_mode (0), so it counts as play.
  - A new status byte arriving in save mode abandons the binding.
- Reset mid-frame aborts reception with no output change except the reset values.

Decomposition:
- Package midi_pkg:
  - MIDI status range constants: STATUS_MIN 8'h80, SYS_MIN 8'hF0.
  - Nibble constants: PC_NIBBLE 4'hC, CP_NIBBLE 4'hD.
  - Receiver state enum: IDLE, START, DATA, STOP.
- One sub-module: btn_debounce (synchroniser + counter, parameter DEBOUNCE_CYCLES, output pressed level), instantiated three times.
- The UART receiver and message assembly stay inline.

Test Plan:
- Use CLKS_PER_BIT=16 and DEBOUNCE_CYCLES=8 throughout.
- Send 0xB0,0x2E,0x7F -> one cycle after the third stop bit: status=B0, data1=2E, data2=7F, bytes_cnt=3, cmd_completed=1, save_mode=1.
- Send 0xC0,0x42 -> status=C0, data1=42, data2=00, bytes_cnt=2, cmd_completed=1. A following 0x55 changes nothing.
- Pull btn2_pin_1 low for 5 cycles with bounce -> btn_index stays 0. Hold low for 20 cycles -> btn_index=2 for exactly one cycle, once. Release -> no pulse.
- After a completed message, press board_btn -> btn_index=1 coincides with save_mode=1; save_mode=0 the next cycle. A second press -> btn_index=1 with save_mode=0.
- A 0.25-bit low glitch on midi_rx produces no byte. A byte with stop bit 0 in the middle of 0x90,0x3C,<bad> gives no completion; then 0x90,0x3C,0x40 completes normally.
- Assert rst_i mid-byte -> all outputs 0 the next cycle. A clean 0xC0,0x43 afterwards completes with data1=43.
